// File: rtl/multu_hilo_if.sv
// Bus between the multiply/HI-LO unit and its requester.
//   dataA, dataB : unsigned 32-bit operands, requester -> unit
//   Signal       : 6-bit function code (shared with the ALU funct field)
//   dataOut      : HI or LO readout, unit -> requester
//   busy         : multiply in progress
//   done         : one-cycle completion pulse
interface multu_hilo_if;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  modport master (
    output dataA, dataB, Signal,
    input  dataOut, busy, done
  );

  modport slave (
    input  dataA, dataB, Signal,
    output dataOut, busy, done
  );
endinterface

// File: rtl/multu_hilo.sv
// Sequential unsigned 32x32 multiplier with HI/LO result registers.
// A MULTU code in IDLE latches the operands and runs 32 shift-add steps;
// the 64-bit result lands in HI/LO on the last step and done pulses for
// one cycle. MFHI/MFLO read HI/LO combinationally at any time; during a
// multiply they still show the previous result.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : multu_hilo_if.slave (dataA, dataB, Signal, dataOut, busy, done)
module multu_hilo #(
  parameter logic [5:0] MULTU = 6'b011001,
  parameter logic [5:0] MFHI  = 6'b010000,
  parameter logic [5:0] MFLO  = 6'b010010
) (
  input  logic          clk,
  input  logic          reset,
  multu_hilo_if.slave   bus
);

  typedef enum logic {IDLE, RUN} stateT;

  stateT       state;
  logic [31:0] multiplicand;
  logic [63:0] product;
  logic [4:0]  counter;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic        doneReg;
  logic [63:0] nextProduct;

  // One shift-add step. The sum keeps its 33rd (carry) bit, which shifts
  // into product[63], so no result bit is lost even for all-ones operands.
  function automatic logic [63:0] shiftAddStep(input logic [63:0] prod,
                                               input logic [31:0] mcand);
    logic [32:0] sum;
    if (prod[0]) sum = {1'b0, prod[63:32]} + {1'b0, mcand};
    else         sum = {1'b0, prod[63:32]};
    return {sum, prod[31:1]};
  endfunction

  assign nextProduct = shiftAddStep(product, multiplicand);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      multiplicand <= 32'd0;
      product      <= 64'd0;
      counter      <= 5'd0;
      hiReg        <= 32'd0;
      loReg        <= 32'd0;
      doneReg      <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Signal == MULTU) begin
            state        <= RUN;
            multiplicand <= bus.dataA;
            product      <= {32'd0, bus.dataB};
            counter      <= 5'd0;
          end
        end
        RUN: begin
          // MULTU codes seen here are ignored; the operation runs to completion.
          product <= nextProduct;
          counter <= counter + 5'd1;
          if (counter == 5'd31) begin
            hiReg   <= nextProduct[63:32];
            loReg   <= nextProduct[31:0];
            doneReg <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = doneReg;
  assign bus.dataOut = (bus.Signal == MFHI) ? hiReg :
                       (bus.Signal == MFLO) ? loReg : 32'd0;

endmodule

// File: doc/multu_hilo.md
MULTU_HILO -- requirements
Module: multu_hilo

Interface
Parameters:
REQ-001 The block SHALL define parameter MULTU, default 6'b011001, the unsigned-multiply function code.
REQ-002 The block SHALL define parameter MFHI, default 6'b010000, the move-from-HI function code.
REQ-003 The block SHALL define parameter MFLO, default 6'b010010, the move-from-LO function code.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port dataA, input, 32 bits: the multiplicand, unsigned.
REQ-007 The block SHALL have port dataB, input, 32 bits: the multiplier, unsigned.
REQ-008 The block SHALL have port Signal, input, 6 bits: the function code, shared with the ALU funct field.
REQ-009 The block SHALL have port dataOut, output, 32 bits: the HI or LO readout.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse on multiply completion.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 IDLE -> RUN SHALL occur on a rising edge where state==IDLE and Signal==MULTU.
- On that same edge the block SHALL latch dataA into a 32-bit multiplicand register.
- It SHALL load the 64-bit product register with {32'b0, dataB}.
- It SHALL clear the 5-bit iteration counter.
REQ-014 In RUN, each edge SHALL perform one shift-add step:
- If product[0]==1, the block SHALL form the 33-bit sum {1'b0, product[63:32]} + {1'b0, multiplicand}; otherwise it SHALL use {1'b0, product[63:32]}.
- The product SHALL become {sum[32:0], product[31:1]}.
- The counter SHALL increment.
REQ-015 The 33-bit carry SHALL be preserved, so that no result bit is lost for any operand pair.
REQ-016 On the RUN edge where the counter equals 31 (the 32nd step), the block SHALL:
- write the final product[63:32] to HI and product[31:0] to LO;
- return to IDLE;
- assert done for exactly the following cycle.
REQ-017 Latency SHALL be 32 cycles: for acceptance at edge N, HI/LO SHALL hold the result after edge N+32, with done high between edges N+32 and N+33.
REQ-018 busy SHALL equal (state==RUN).
REQ-019 Signal==MULTU while busy SHALL be ignored: no restart, no operand latch, and the in-flight operation SHALL be unaffected.
REQ-020 HI and LO SHALL change only at completion or reset; they SHALL hold their value while busy.
REQ-021 dataOut SHALL be combinational from the registers:
- HI when Signal==MFHI;
- LO when Signal==MFLO;
- 32'b0 otherwise.
REQ-022 During RUN, dataOut SHALL return the pre-operation HI/LO; there SHALL be no interlock.
REQ-023 A MULTU presented in IDLE on the cycle done is high SHALL be accepted, giving back-to-back operations.
REQ-024 Changes on dataA/dataB after acceptance SHALL NOT affect the result.
REQ-025 The final result SHALL equal dataA*dataB as a 64-bit unsigned value, for all inputs including 0 and 32'hFFFFFFFF.

Reset
REQ-026 When reset is high at a rising edge, the block SHALL set:
- state=IDLE;
- HI=0 and LO=0;
- product=0, multiplicand=0, counter=0;
- done=0.
REQ-027 Reset SHALL take priority over every other action, including a MULTU on the same edge.
REQ-028 Reset during RUN SHALL abort the operation with no HI/LO write and no done pulse.
REQ-029 After reset deasserts, busy=0, done=0, and dataOut=0 for MFHI or MFLO.

Verification
REQ-030 Basic multiply: reset, then MULTU with A=3, B=5 -> busy high for 32 cycles, one-cycle done pulse, then MFHI=0 and MFLO=15.
REQ-031 Maximum operands: MULTU with A=B=32'hFFFFFFFF -> MFHI=32'hFFFFFFFE and MFLO=32'h00000001.
REQ-032 Ignored restart and stale readout: with the prior result HI=0, LO=15, present MULTU A=7, B=9 and hold MULTU with A=2, B=2 for 10 more cycles -> the final result SHALL be HI=0, LO=63, and MFLO SHALL read 15 until completion.
REQ-033 Reset mid-operation: MULTU A=32'h10000, B=32'h10000, then reset at cycle 12 -> HI=LO=0, no done pulse, busy=0.
REQ-034 Back-to-back: MULTU asserted on the done cycle with A=0, B=32'h12345678 -> accepted, and after 32 cycles HI=LO=0.
REQ-035 Non-matching code: Signal=6'b100000 -> dataOut=0 and no state change.
